rate_down_counter: RTL

//   Loadable down-counter / rate divider: the counting-down counterpart of the
//   8-bit T-flip-flop up-counter. Counts from a selectable preset to 0, emits a
//   one-cycle Pulse on each terminal count, then reloads.
//   A 4-bit decade digit counts down 9..0 once per Pulse to drive a HEX display.

---
 rtl/rate_down_counter.sv | 104 ++++++++++
 1 files changed

// File: rtl/rate_down_counter.sv
// Loadable down-counter / rate divider with a 9..0 decade digit for a HEX display.
// Define DOWNCNT_ONESHOT_EN to stop at 0 after one terminal count instead of auto-reloading.
module rate_down_counter #(
    parameter int WIDTH   = 8,
    parameter int PRESET0 = 0,
    parameter int PRESET1 = 3,
    parameter int PRESET2 = 99,
    parameter int PRESET3 = 255
) (
    input  logic             Clock,
    input  logic             Clear_b,
    input  logic             Enable,
    input  logic [1:0]       Speed,
    input  logic             Load,
    input  logic [WIDTH-1:0] ParLoad,
    output logic [WIDTH-1:0] CounterValue,
    output logic             Pulse,
    output logic [3:0]       DigitValue
);

    // Presets wider than WIDTH are deliberately truncated.
    localparam logic [WIDTH-1:0] P0 = WIDTH'(PRESET0);
    localparam logic [WIDTH-1:0] P1 = WIDTH'(PRESET1);
    localparam logic [WIDTH-1:0] P2 = WIDTH'(PRESET2);
    localparam logic [WIDTH-1:0] P3 = WIDTH'(PRESET3);

    logic [WIDTH-1:0] preset;
    logic [3:0]       digit_next;
    logic             terminal;

    always_comb begin
        preset = P0;
        case (Speed)
            2'b00:   preset = P0;
            2'b01:   preset = P1;
            2'b10:   preset = P2;
            default: preset = P3;
        endcase
    end

    always_comb begin
        digit_next = 4'd9;
        if (DigitValue != 4'd0 && DigitValue <= 4'd9)
            digit_next = DigitValue - 4'd1;
    end

    assign terminal = (CounterValue == '0);

`ifdef DOWNCNT_ONESHOT_EN
    // Set once the single terminal count has fired; only Load or Clear_b rearm.
    logic done;

    always_ff @(posedge Clock) begin
        if (!Clear_b) begin
            CounterValue <= preset;
            Pulse        <= 1'b0;
            DigitValue   <= 4'd9;
            done         <= 1'b0;
        end else if (Load) begin
            CounterValue <= ParLoad;
            Pulse        <= 1'b0;
            done         <= 1'b0;
        end else if (Enable) begin
            if (done) begin
                Pulse <= 1'b0;
            end else if (!terminal) begin
                CounterValue <= CounterValue - 1'b1;
                Pulse        <= 1'b0;
            end else begin
                CounterValue <= '0;
                Pulse        <= 1'b1;
                DigitValue   <= digit_next;
                done         <= 1'b1;
            end
        end else begin
            Pulse <= 1'b0;
        end
    end
`else
    // Speed is consulted only here and at reset, so a mid-count change waits for reload.
    always_ff @(posedge Clock) begin
        if (!Clear_b) begin
            CounterValue <= preset;
            Pulse        <= 1'b0;
            DigitValue   <= 4'd9;
        end else if (Load) begin
            CounterValue <= ParLoad;
            Pulse        <= 1'b0;
        end else if (Enable) begin
            if (!terminal) begin
                CounterValue <= CounterValue - 1'b1;
                Pulse        <= 1'b0;
            end else begin
                CounterValue <= preset;
                Pulse        <= 1'b1;
                DigitValue   <= digit_next;
            end
        end else begin
            Pulse <= 1'b0;
        end
    end
`endif

endmodule
